// File: rtl/cpu_mem_arbiter_if.sv
// Purpose : bundles the CPU fetch port, CPU load/store port and the memory command port.
// Ports   : pc_* (fetch request, waitreq, read return), ldst_* (load/store request, waitreq,
//           read return), mem_* (single-port memory command and 1-cycle-latency read data).
// Modports: slave = arbiter side, master = CPU + memory side.
interface cpu_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  // Fetch port
  logic [ADDR_W-1:0] i_pc_addr;
  logic              i_pc_rd;
  logic              o_pc_waitreq;
  logic [DATA_W-1:0] o_pc_rddata;
  logic              o_pc_rddata_valid;
  // Load/store port
  logic [ADDR_W-1:0] i_ldst_addr;
  logic              i_ldst_rd;
  logic              i_ldst_wr;
  logic [DATA_W-1:0] i_ldst_wrdata;
  logic              o_ldst_waitreq;
  logic [DATA_W-1:0] o_ldst_rddata;
  logic              o_ldst_rddata_valid;
  // Memory port
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_rd;
  logic              o_mem_wr;
  logic [DATA_W-1:0] o_mem_wrdata;
  logic [DATA_W-1:0] i_mem_rddata;

  modport slave (
    input  i_pc_addr, i_pc_rd,
    output o_pc_waitreq, o_pc_rddata, o_pc_rddata_valid,
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    output o_ldst_waitreq, o_ldst_rddata, o_ldst_rddata_valid,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
    input  i_mem_rddata
  );

  modport master (
    output i_pc_addr, i_pc_rd,
    input  o_pc_waitreq, o_pc_rddata, o_pc_rddata_valid,
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    input  o_ldst_waitreq, o_ldst_rddata, o_ldst_rddata_valid,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
    output i_mem_rddata
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// Purpose : arbitrates CPU fetch and load/store onto one single-port memory; ldst has priority,
//           fetch is forced in after MAX_LDST_STREAK consecutive ldst grants while it waits.
// Latency : command is combinational from the grant; read data valid 1 cycle after acceptance.
// Backpr. : per-port waitreq, combinational, high only while the port requests and is not granted.
// Ports   : clk, reset (sync, active-low), bus (cpu_mem_arbiter_if.slave: pc_*, ldst_*, mem_*).
module cpu_mem_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int MAX_LDST_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_mem_arbiter_if.slave      bus
);

  typedef enum logic {S_LDST, S_FORCE_PC} state_e;

  state_e            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              tag_vld_q, tag_vld_d;
  logic              tag_pc_q, tag_pc_d;   // owner of the read in flight: 1 = fetch, 0 = ldst

  logic              ldst_req;
  logic              grant_pc;
  logic              grant_ldst;
  logic              ldst_is_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rd_dat;

  assign ldst_req   = bus.i_ldst_rd | bus.i_ldst_wr;
  // A simultaneous rd+wr is treated as a store only.
  assign ldst_is_rd = bus.i_ldst_rd & ~bus.i_ldst_wr;

  // Arbitration: next state, streak and grants.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    grant_pc   = 1'b0;
    grant_ldst = 1'b0;

    if (reset) begin
      case (state_q)
        S_LDST: begin
          if (ldst_req) begin
            grant_ldst = 1'b1;
            if (bus.i_pc_rd) begin
              streak_d = streak_q + 4'd1;
              if (streak_d == 4'(MAX_LDST_STREAK)) begin
                state_d = S_FORCE_PC;
              end
            end else begin
              streak_d = 4'd0;
            end
          end else begin
            // Either fetch takes the free slot or nobody waits; both end the streak.
            grant_pc = bus.i_pc_rd;
            streak_d = 4'd0;
          end
        end
        S_FORCE_PC: begin
          state_d  = S_LDST;
          streak_d = 4'd0;
          if (bus.i_pc_rd) begin
            grant_pc = 1'b1;
          end else begin
            // Fetch withdrew its request, so the forced slot goes back to ldst.
            grant_ldst = ldst_req;
          end
        end
        default: begin
          state_d  = S_LDST;
          streak_d = 4'd0;
        end
      endcase
    end
  end

  // Memory command and read-tag capture.
  always_comb begin
    mem_addr = '0;
    if (grant_pc) begin
      mem_addr = bus.i_pc_addr;
    end else if (grant_ldst) begin
      mem_addr = bus.i_ldst_addr;
    end
    tag_vld_d = grant_pc | (grant_ldst & ldst_is_rd);
    tag_pc_d  = grant_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_LDST;
      streak_q  <= 4'd0;
      tag_vld_q <= 1'b0;
      tag_pc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      tag_vld_q <= tag_vld_d;
      tag_pc_q  <= tag_pc_d;
    end
  end

  assign rd_dat = bus.i_mem_rddata;

  assign bus.o_pc_waitreq   = bus.i_pc_rd & ~grant_pc;
  assign bus.o_ldst_waitreq = ldst_req & ~grant_ldst;

  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_rd     = grant_pc | (grant_ldst & ldst_is_rd);
  assign bus.o_mem_wr     = grant_ldst & bus.i_ldst_wr;
  assign bus.o_mem_wrdata = bus.i_ldst_wrdata;

  // Valids are qualified by reset so a read in flight when reset lands is never returned.
  assign bus.o_pc_rddata         = rd_dat;
  assign bus.o_ldst_rddata       = rd_dat;
  assign bus.o_pc_rddata_valid   = reset & tag_vld_q & tag_pc_q;
  assign bus.o_ldst_rddata_valid = reset & tag_vld_q & ~tag_pc_q;

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between the CPU's two ports.
  - Requester A: instruction fetch (pc_* port).
  - Requester B: load/store (ldst_* port).
- Default policy is fixed priority to load/store, so in-flight loads and stores drain first.
- A streak counter forces a fetch grant after MAX_LDST_STREAK consecutive load/store grants, so fetch is never starved.
- Stalls are signalled back to the CPU with per-port waitrequest. Read data is steered to the requester with a registered tag.

Parameters:
- ADDR_W, 16, byte address width of CPU ports and memory port.
- DATA_W, 16, data width.
- MAX_LDST_STREAK, 4, number of consecutive ldst grants allowed while a fetch is pending. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- i_pc_addr  in  ADDR_W  fetch address.
- i_pc_rd  in  1  fetch request; held with address until accepted.
- o_pc_waitreq  out  1  1 = fetch not accepted this cycle.
- o_pc_rddata  out  DATA_W  fetch read data.
- o_pc_rddata_valid  out  1  1-cycle pulse when o_pc_rddata is valid.
- i_ldst_addr  in  ADDR_W  load/store address.
- i_ldst_rd  in  1  load request.
- i_ldst_wr  in  1  store request.
- i_ldst_wrdata  in  DATA_W  store data.
- o_ldst_waitreq  out  1  1 = load/store not accepted this cycle.
- o_ldst_rddata  out  DATA_W  load read data.
- o_ldst_rddata_valid  out  1  1-cycle pulse when o_ldst_rddata is valid.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_rd  out  1  memory read strobe.
- o_mem_wr  out  1  memory write strobe.
- o_mem_wrdata  out  DATA_W  memory write data.
- i_mem_rddata  in  DATA_W  memory read data, 1-cycle latency after o_mem_rd.

Behaviour:
- Handshake:
  - A request is accepted on a rising edge where its request is high and its waitreq is low.
  - The requester holds address, data and strobes stable while waitreq is high.
  - waitreq is combinational from the requests and the arbiter state. It is 0 whenever the port is not requesting.
- Arbitration FSM, registered:
  - State S_LDST: ldst has priority.
  - State S_FORCE_PC: fetch has priority.
  - The registered 4-bit counter streak counts consecutive ldst grants made while i_pc_rd=1.
- Grant in S_LDST:
  - If ldst requests, ldst is granted. If also i_pc_rd=1, streak increments.
  - If streak reaches MAX_LDST_STREAK on that grant, the next state is S_FORCE_PC.
  - Otherwise, if i_pc_rd=1, pc is granted and streak clears.
  - streak clears on any cycle where i_pc_rd=0.
- Grant in S_FORCE_PC:
  - If i_pc_rd=1, pc is granted, streak clears and the FSM returns to S_LDST.
  - If i_pc_rd=0 (request withdrawn), the FSM returns to S_LDST with no forced grant, and ldst may be granted that cycle.
- Exactly one port is granted per cycle, at most.
- Memory command (combinational from the grant):
  - o_mem_addr is the granted port's address.
  - o_mem_rd = granted & read.
  - o_mem_wr = granted ldst & i_ldst_wr.
  - o_mem_wrdata = i_ldst_wrdata.
  - When nothing is granted: o_mem_rd=0, o_mem_wr=0, o_mem_addr=0.
- i_ldst_rd and i_ldst_wr both high is illegal. The store wins, no read is issued, and no ldst valid pulse follows.
- Read return:
  - A registered tag {valid, owner} is captured when a read is granted.
  - The next cycle pulses exactly one of o_pc_rddata_valid / o_ldst_rddata_valid.
  - o_pc_rddata and o_ldst_rddata both equal i_mem_rddata combinationally; the valid flags disambiguate.
  - Stores produce no valid pulse.
- Throughput: one access per cycle, back-to-back, no bubbles. Read latency is 1 cycle from acceptance edge to valid.
- Reset (reset=0 at an edge):
  - FSM goes to S_LDST, streak=0, tag valid=0.
  - Both rddata_valid are 0 in the following cycle.
  - While reset=0: both waitreq are 1 when requesting, and o_mem_rd=o_mem_wr=0.
  - A read accepted in the cycle before reset asserts produces no valid pulse if reset is low at the return edge.
- Address is passed through unmodified. Alignment is the memory's concern.

Test Plan:
- Idle then pc_rd, addr=0x0010, mem returns 0xBEEF:
  - pc_waitreq=0 at issue, o_mem_rd=1, o_mem_addr=0x0010.
  - Next cycle o_pc_rddata_valid=1 with data 0xBEEF. ldst valid stays 0.
- pc_rd and ldst_wr (addr 0x0100, data 0x1234) in the same cycle:
  - ldst granted: o_mem_wr=1, o_mem_wrdata=0x1234, pc_waitreq=1.
  - Next cycle pc granted. No valid pulse for the write.
- pc_rd held high, ldst_rd continuously for 10 cycles (MAX_LDST_STREAK=4):
  - Grant pattern is L,L,L,L,P,L,L,L,L,P.
  - Valid pulses alternate to match, 1 cycle later.
- Back-to-back ldst_rd to 0x0002, 0x0004, 0x0006 with no pc request:
  - 3 consecutive o_ldst_rddata_valid pulses, each 1 cycle after its grant.
  - Data matches the memory model; streak stays 0.
- pc_rd accepted, then reset=0 at the next edge:
  - No o_pc_rddata_valid pulse.
  - After reset=1: FSM is in S_LDST; with both requesting, the first grant is ldst.
- ldst_rd and ldst_wr both high, addr 0x0008, data 0x5555:
  - o_mem_wr=1, o_mem_rd=0.
  - No ldst valid pulse; the memory model holds 0x5555 at 0x0008.
